// File: rtl/if_id_queue.sv
// Fetch queue between PC/imem and decode; buffers DEPTH {pc, inst} pairs in order, 1-cycle min latency.
// in_ready (PC enable) falls only when full, independent of out_ready; flush empties the queue.
module if_id_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_inst,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_inst_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign in_ready  = (r_count < FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign level     = r_count;

    // Empty queue presents a NOP at the reset PC so decode sees a harmless default.
    assign out_pc    = out_valid ? r_pc_mem[r_rptr]   : RESET_PC;
    assign out_inst  = out_valid ? r_inst_mem[r_rptr] : 32'h0000_0000;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= in_pc;
            r_inst_mem[r_wptr] <= in_inst;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, async reset sequence, and random traffic against a queue model.
module tb_if_id_queue;
    localparam int          DEPTH = 2;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] RPC   = 32'h0040_0000;

    logic          clock, reset, flush, in_valid, out_ready;
    logic [31:0]   in_pc, in_inst;
    logic          in_ready, out_valid;
    logic [31:0]   out_pc, out_inst;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    if_id_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .level(level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic          fl;
        logic          iv;
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic          ordy;
        logic          ev;
        logic [31:0]   epc;
        logic [31:0]   einst;
        logic [LW-1:0] elvl;
        logic          eir;
    } vec_t;

    vec_t      vt[$];
    bit [63:0] mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einst, input logic [LW-1:0] elvl, input logic eir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_pc"},    out_pc,         epc);
        chk({tag, ".out_inst"},  out_inst,       einst);
        chk({tag, ".level"},     32'(level),     32'(elvl));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(eir));
    endtask

    task automatic chk_model(input string tag);
        if (mq.size() == 0) chk_all(tag, 1'b0, RPC, 32'h0, '0, 1'b1);
        else chk_all(tag, 1'b1, mq[0][63:32], mq[0][31:0], LW'(mq.size()), mq.size() < DEPTH);
    endtask

    // Reference queue semantics: accept when not full, consume when non-empty, flush/reset empties.
    task automatic model_edge();
        bit can_push, can_pop;
        can_push = mq.size() < DEPTH;
        can_pop  = mq.size() != 0;
        if (!reset || flush) mq.delete();
        else begin
            if (can_pop && out_ready)  void'(mq.pop_front());
            if (can_push && in_valid)  mq.push_back({in_pc, in_inst});
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic add(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                       input int elvl, input logic eir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
        v.ev = ev; v.epc = epc; v.einst = einst; v.elvl = LW'(elvl); v.eir = eir;
        vt.push_back(v);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;

        // Expected values are the state after the edge on which the vector is applied.
        add(0, 1, 32'h0040_0000, 32'h3C01_1001, 0, 1, 32'h0040_0000, 32'h3C01_1001, 1, 1);
        add(0, 1, 32'h0040_0004, 32'h1111_1111, 0, 1, 32'h0040_0000, 32'h3C01_1001, 2, 0);
        add(0, 1, 32'h0040_0008, 32'h2222_2222, 0, 1, 32'h0040_0000, 32'h3C01_1001, 2, 0);
        add(0, 1, 32'h0040_0008, 32'h2222_2222, 1, 1, 32'h0040_0004, 32'h1111_1111, 1, 1);
        add(0, 1, 32'h0040_0008, 32'h2222_2222, 0, 1, 32'h0040_0004, 32'h1111_1111, 2, 0);
        add(0, 0, 32'h0, 32'h0, 1, 1, 32'h0040_0008, 32'h2222_2222, 1, 1);
        add(0, 0, 32'h0, 32'h0, 1, 0, RPC, 32'h0, 0, 1);
        add(0, 0, 32'h0, 32'h0, 1, 0, RPC, 32'h0, 0, 1);
        for (int k = 0; k < 10; k++)
            add(0, 1, RPC + 32'(4 * k), 32'hA000_0000 + 32'(k), 1,
                1, RPC + 32'(4 * k), 32'hA000_0000 + 32'(k), 1, 1);
        add(0, 0, 32'h0, 32'h0, 1, 0, RPC, 32'h0, 0, 1);
        add(0, 1, 32'h0040_0000, 32'hB000_0000, 0, 1, 32'h0040_0000, 32'hB000_0000, 1, 1);
        add(0, 1, 32'h0040_0004, 32'hB000_0001, 0, 1, 32'h0040_0000, 32'hB000_0000, 2, 0);
        add(1, 1, 32'h0040_0008, 32'hCCCC_CCCC, 1, 0, RPC, 32'h0, 0, 1);
        add(0, 0, 32'h0, 32'h0, 1, 0, RPC, 32'h0, 0, 1);
        add(0, 1, 32'h0040_000C, 32'hD000_0000, 0, 1, 32'h0040_000C, 32'hD000_0000, 1, 1);
        add(0, 0, 32'h0, 32'h0, 1, 0, RPC, 32'h0, 0, 1);

        #2;
        chk_all("reset_async", 1'b0, RPC, 32'h0, '0, 1'b1);
        cycle();
        cycle();
        chk_all("reset_held", 1'b0, RPC, 32'h0, '0, 1'b1);
        reset = 1'b1;
        cycle();
        chk_all("idle", 1'b0, RPC, 32'h0, '0, 1'b1);

        for (int i = 0; i < vt.size(); i++) begin
            flush = vt[i].fl; in_valid = vt[i].iv; in_pc = vt[i].pc;
            in_inst = vt[i].inst; out_ready = vt[i].ordy;
            cycle();
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einst, vt[i].elvl, vt[i].eir);
        end

        // Asynchronous reset between edges while full.
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h0040_0100; in_inst = 32'hE000_0000;
        cycle();
        in_pc = 32'h0040_0104; in_inst = 32'hE000_0001;
        cycle();
        chk_all("pre_arst", 1'b1, 32'h0040_0100, 32'hE000_0000, 2'd2, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_all("mid_arst", 1'b0, RPC, 32'h0, '0, 1'b1);
        mq.delete();
        cycle();
        reset = 1'b1;
        cycle();
        chk_model("post_arst");

        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = $urandom;
            in_inst   = $urandom;
            cycle();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue sitting directly downstream of the program counter register, between instruction memory and the decode stage. It captures each fetched (PC, instruction) pair, buffers up to DEPTH of them, and presents them in order to decode with a valid/ready handshake. Its `in_ready` output drives the PC register's enable, so the PC advances only when the queue can accept the instruction at the current PC. A `flush` input discards all buffered instructions on a branch or jump redirect.

## Interface
- DEPTH, 2, number of queue entries; power of two, ≥ 2.
- RESET_PC, 32'h00400000, PC value driven on `out_pc` while the queue is empty.

- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- flush  input  1  synchronous discard of all entries and of the current push.
- in_valid  input  1  fetch side presents a valid instruction.
- in_pc  input  32  PC of the presented instruction.
- in_inst  input  32  instruction word read from instruction memory.
- in_ready  output  1  queue can accept a push this cycle; drives the PC register enable.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_inst  output  32  instruction of the head entry.
- out_ready  input  1  decode consumes the head this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}, a write pointer and a read pointer ($clog2(DEPTH) bits each, wrapping modulo DEPTH), and an occupancy count.
- in_ready = (count < DEPTH). It is combinational from count only and does not depend on out_ready, so there is no same-cycle pass-through when full.
- push = in_valid & in_ready & ~flush. The entry is written at wptr, and wptr increments.
- pop = out_valid & out_ready & ~flush. rptr increments.
- count_next = count + push − pop. A push and a pop in the same cycle leave the count unchanged.
- out_valid = (count != 0).
- When out_valid=1, out_pc and out_inst come from the entry at rptr.
- When out_valid=0, out_pc = RESET_PC and out_inst = 32'h00000000 (NOP).
- level = count.
- flush has priority over everything. On the next edge: count=0, wptr=0, rptr=0. The push and pop in that cycle are both suppressed.
- Entry contents are not cleared by flush or reset. Only the pointers and count are cleared.

## Timing
- Reset (reset=0, asynchronous): count=0, wptr=0, rptr=0, out_valid=0, in_ready=1, level=0, out_pc=RESET_PC, out_inst=0. All of these hold immediately, without waiting for a clock edge.
- Reset deassertion is sampled at the next rising edge. The first push can occur on that edge.
- Latency: an instruction pushed at edge N is visible on out_* with out_valid=1 during the cycle after edge N. Minimum occupancy time is 1 cycle.
- Throughput: with out_ready held at 1, one push and one pop per cycle in steady state, and count stays at 1.
- Full (count=DEPTH): in_ready=0, so the PC holds. out_ready=1 pops at the edge, and in_ready returns to 1 in the following cycle.
- Empty with out_ready=1: no pop, and the count does not underflow.
- Pointer wrap: after DEPTH pushes, wptr returns to 0. Ordering is preserved across the wrap.
- Flush while full or with a simultaneous push/pop: the queue is empty after the edge, and in_ready=1 in the next cycle.
- Reset asserted mid-operation: state clears immediately regardless of clock.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, level=0, out_pc=32'h00400000, out_inst=0 both during and after reset.
- Push {0x00400000, 0x3C011001} with out_ready=0:
  - Next cycle: out_valid=1, out_pc=0x00400000, out_inst=0x3C011001, level=1.
  - A second push makes level=2 and in_ready=0.
- Fill to DEPTH=2 with PCs 0x00400000 and 0x00400004, keep in_valid=1 with PC 0x00400008 and out_ready=0:
  - in_ready stays 0 and the third instruction is not accepted.
  - Raise out_ready for one cycle: 0x00400000 is popped, then 0x00400008 is accepted on the following edge.
- Streaming with in_valid=out_ready=1 for 10 cycles, PCs 0x00400000 upward in steps of 4:
  - Outputs appear in order, one cycle after each push.
  - level stays 1, and pointers wrap several times without loss.
- Flush at full with in_valid=1 and out_ready=1 in the same cycle:
  - Next cycle: level=0, out_valid=0, out_pc=0x00400000.
  - The flushed-cycle instruction is absent from all subsequent output.
- Reset asserted asynchronously between edges while level=2: outputs drop to their reset values before the next clock edge.
